// File: rtl/btn_req_latch4.sv
// Four-channel button conditioner: 2-flop sync, debounce, rise detect, sticky request latch.
// Latency: a held press shows on PULSE/REQ DB_CYCLES+2 edges after BTN is first captured.
// Backpressure: none; presses on an already-pending channel are absorbed until cleared by index.
module btn_req_latch4 #(
    parameter int DB_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] BTN,
    input  logic       CLR_EN,
    input  logic [1:0] CLR_IDX,
    output logic [3:0] REQ,
    output logic [3:0] PULSE,
    output logic       ANY
);
    localparam int               CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       stable;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       flip;
    logic [3:0]       rise;

    // flip marks the DB_CYCLES-th consecutive disagreeing sample; only a flip to 1 is a press
    always_comb begin
        flip = '0;
        rise = '0;
        for (int i = 0; i < 4; i++) begin
            flip[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_LAST);
            rise[i] = flip[i] && s2[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            PULSE  <= '0;
            REQ    <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            s1    <= BTN;
            s2    <= s1;
            PULSE <= rise;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
                // a new press beats a same-edge clear so it is never lost
                if (rise[i]) begin
                    REQ[i] <= 1'b1;
                end else if (CLR_EN && (CLR_IDX == 2'(i))) begin
                    REQ[i] <= 1'b0;
                end
            end
        end
    end

    assign ANY = |REQ;

endmodule

// File: tb/tb_btn_req_latch4.sv
module tb_btn_req_latch4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] BTN = '0;
    logic       CLR_EN = 1'b0;
    logic [1:0] CLR_IDX = '0;
    logic [3:0] REQ;
    logic [3:0] PULSE;
    logic       ANY;

    btn_req_latch4 #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .BTN(BTN), .CLR_EN(CLR_EN), .CLR_IDX(CLR_IDX),
        .REQ(REQ), .PULSE(PULSE), .ANY(ANY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference: line delayed two samples, stable level, length of current disagreeing run
    logic [3:0] m_d1, m_d2, m_lvl, m_req, m_pulse;
    int         m_run [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_req = '0; m_pulse = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_edge();
        logic [3:0] line;
        line    = m_d2;
        m_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            if (line[i] != m_lvl[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] >= DB) begin
                    m_lvl[i]   = line[i];
                    m_run[i]   = 0;
                    m_pulse[i] = line[i];
                end
            end else begin
                m_run[i] = 0;
            end
            if (m_pulse[i]) m_req[i] = 1'b1;
            else if (CLR_EN && CLR_IDX == i[1:0]) m_req[i] = 1'b0;
        end
        m_d2 = m_d1;
        m_d1 = BTN;
    endtask

    task automatic step(input logic [3:0] b, input logic ce, input logic [1:0] ci);
        BTN = b; CLR_EN = ce; CLR_IDX = ci;
        @(posedge clk);
        model_edge();
        #1;
        check("req", 32'(REQ), 32'(m_req));
        check("pulse", 32'(PULSE), 32'(m_pulse));
        check("any", 32'(ANY), 32'(|m_req));
    endtask

    // drive b for n cycles; returns edge number of first PULSE on channel ch (99 if none) and pulse count
    task automatic run(input logic [3:0] b, input int n, input int ch, output int first, output int cnt);
        first = 99; cnt = 0;
        for (int k = 1; k <= n; k++) begin
            step(b, 1'b0, 2'd0);
            if (PULSE[ch]) begin
                cnt++;
                if (first == 99) first = k;
            end
        end
    endtask

    initial begin
        int f, c, c2;
        logic [3:0] cur;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(REQ), 0);
        check("rst_pulse", 32'(PULSE), 0);
        check("rst_any", 32'(ANY), 0);
        rst = 1'b0;

        // single press after reset
        run(4'b0001, 14, 0, f, c);
        check("press_edge", f, 10);
        check("press_count", c, 1);
        check("press_req", 32'(REQ), 32'h1);
        check("press_any", 32'(ANY), 1);
        run(4'b0000, 15, 0, f, c);
        check("release_pulse", c, 0);

        // glitch reject then minimum accepted width on channel 2
        run(4'b0100, 7, 2, f, c);
        run(4'b0000, 15, 2, f, c2);
        check("glitch7_pulses", c + c2, 0);
        check("glitch7_req", 32'(REQ), 32'h1);
        run(4'b0100, 8, 2, f, c);
        run(4'b0000, 15, 2, f, c2);
        check("glitch8_pulses", c + c2, 1);
        check("glitch8_req", 32'(REQ), 32'h5);

        // simultaneous press, then clear by index
        step(4'b0000, 1'b1, 2'd0);
        step(4'b0000, 1'b1, 2'd2);
        check("clr_all", 32'(REQ), 0);
        run(4'b1010, 12, 1, f, c);
        check("multi_edge", f, 10);
        check("multi_req", 32'(REQ), 32'ha);
        step(4'b1010, 1'b1, 2'd1);
        check("clr1_req", 32'(REQ), 32'h8);
        step(4'b1010, 1'b1, 2'd3);
        check("clr3_req", 32'(REQ), 0);
        check("clr3_any", 32'(ANY), 0);
        run(4'b0000, 15, 0, f, c);

        // set/clear collision on channel 0 with REQ[0] already pending
        run(4'b0001, 12, 0, f, c);
        run(4'b0000, 15, 0, f, c);
        check("coll_pre", 32'(REQ[0]), 1);
        run(4'b0001, 9, 0, f, c);
        step(4'b0001, 1'b1, 2'd0);
        check("coll_pulse", 32'(PULSE[0]), 1);
        check("coll_req", 32'(REQ[0]), 1);
        run(4'b0000, 15, 0, f, c);

        // bounce train on channel 3
        c = 0;
        for (int k = 0; k < 40; k++) begin
            step((((k / 3) % 2) != 0) ? 4'b1000 : 4'b0000, 1'b0, 2'd0);
            if (PULSE[3]) c++;
        end
        run(4'b1000, 15, 3, f, c2);
        check("bounce_press", c + c2, 1);
        check("bounce_req", 32'(REQ[3]), 1);
        c = 0;
        for (int k = 0; k < 40; k++) begin
            step((((k / 3) % 2) != 0) ? 4'b0000 : 4'b1000, 1'b0, 2'd0);
            if (PULSE[3]) c++;
        end
        run(4'b0000, 15, 3, f, c2);
        check("bounce_release", c + c2, 0);

        // async reset mid-debounce
        run(4'b1111, 12, 0, f, c);
        run(4'b0000, 15, 0, f, c);
        check("pre_rst_req", 32'(REQ), 32'hf);
        run(4'b0010, 7, 1, f, c);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(REQ), 0);
        check("arst_pulse", 32'(PULSE), 0);
        check("arst_any", 32'(ANY), 0);
        model_reset();
        #1 rst = 1'b0;
        run(4'b0010, 14, 1, f, c);
        check("arst_recover_edge", f, 10);
        check("arst_recover_req", 32'(REQ), 32'h2);

        // random soak against the reference
        cur = '0;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 9) == 0) cur = 4'($urandom);
            step(cur, ($urandom_range(0, 2) == 0), 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
